uart_rx_multi: RTL and testbench
================================

Name: uart_rx_multi

Overview:
- Parametrised UART receiver: configurable data width, stop-bit count and oversampling ratio.
- Detects framing errors and filters false starts.
- Replaces the fixed 8N1 receiver at the serial input of every board top.
- Output is a one-clock strobe plus a held data word; the consumer needs no handshake back.

Parameters:
- CLOCK_HZ, 10_000_000, system clock frequency in Hz.
- BAUD, 115200, line bit rate.
- OVERSAMPLE, 16, sample ticks per bit. Legal values: 8 or 16.
- DATA_BITS, 8, data bits per frame. Legal range: 5..9.
- STOP_BITS, 1, stop bits checked. Legal values: 1 or 2.

Ports:
- Clock, input, 1, system clock; all logic on the rising edge.
- Reset, input, 1, asynchronous, active-high.
- Rx_i, input, 1, serial line, asynchronous to Clock, idle high.
- Data_o, output, DATA_BITS, last received word, LSB = first data bit on the line.
- Done_o, output, 1, one-clock pulse when a frame completes without error.
- FrameError_o, output, 1, one-clock pulse when a stop bit is sampled low.
- ParityError_o, output, 1, one-clock pulse on parity mismatch. Tied 0 when parity is not compiled in.
- Busy_o, output, 1, high from confirmed start bit until return to IDLE.

Behaviour:
- Reset values:
  - Data_o = 0; Done_o, FrameError_o, ParityError_o, Busy_o = 0.
  - Synchroniser flops = 1; FSM = IDLE.
- Synchronisation:
  - Rx_i passes through a 2-flop synchroniser. All decisions use the synchronised value (rx_s).
- Tick generator:
  - Period TICKS = CLOCK_HZ / (BAUD*OVERSAMPLE), integer division. Elaboration error if TICKS < 1.
  - Counter is held at 0 in IDLE and restarts on start detection, so sampling phase is aligned to the falling edge.
- Sampling:
  - Each bit is sampled once, at the tick where the per-bit tick counter equals OVERSAMPLE/2-1 (mid-bit).
  - The tick counter wraps at OVERSAMPLE-1.
- FSM states:
  - IDLE: rx_s falling edge (previous 1, current 0) -> START. Busy_o stays 0.
  - START: at mid-bit, rx_s=0 -> DATA and Busy_o=1. rx_s=1 -> false start, return to IDLE with no output pulse.
  - DATA: shift rx_s into a DATA_BITS shift register at each mid-bit, LSB first. After DATA_BITS samples -> PARITY if compiled in, else STOP.
  - PARITY: sample one bit, compare it, -> STOP.
  - STOP: sample STOP_BITS bits.
    - Any stop sample = 0: FrameError_o pulses and Data_o is NOT updated. -> IDLE if rx_s=1, else BREAK.
    - All stop samples = 1: Data_o <= shift register. Done_o pulses unless a parity error occurred, in which case ParityError_o pulses instead and Data_o is still updated. -> IDLE.
  - BREAK: wait for rx_s=1, then -> IDLE. Prevents a held-low line from re-triggering start detection.
- Latency:
  - Done_o, FrameError_o and ParityError_o assert exactly one clock after the clock that samples the final stop bit.
  - At most one of the three pulses per frame.
- Return to IDLE happens at mid-stop-bit. This allows back-to-back frames with the next start edge half a bit later.
- Data_o holds its value until the next successful frame.
- Reset asserted mid-frame:
  - All state returns to reset values immediately; no pulse is generated.
  - After deassertion, a line sitting low is not treated as a start until a 1->0 edge is seen.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds the PARITY state and a PARITY_ODD parameter (default 0 = even).
  - The expected parity bit makes the XOR of data bits and parity bit equal to PARITY_ODD.
  - A mismatch with valid stop bits pulses ParityError_o instead of Done_o.
- Not defined:
  - No PARITY state, no PARITY_ODD parameter.
  - ParityError_o is constant 0. Frame = start + DATA_BITS + STOP_BITS.

Test Plan:
Bench parameters: CLOCK_HZ=16_000_000, BAUD=1_000_000, OVERSAMPLE=16 (TICKS=1, 16 clocks per bit).
- 8N1, send 0xA5 -> Data_o=0xA5, one Done_o pulse one clock after the stop sample, Busy_o low afterwards.
- Two frames 0x00 then 0xFF back-to-back with no idle gap -> two Done_o pulses, Data_o=0x00 then 0xFF.
- Low glitch of 4 clocks on an idle line -> no pulses, Busy_o returns 0, FSM in IDLE.
- Send 0x3C with stop bit = 0, then hold low 40 clocks, then high -> FrameError_o pulse once, Data_o unchanged, no new start until after the rising edge.
- DATA_BITS=7, STOP_BITS=2, PARITY_EN defined, even parity:
  - 0x41 with parity bit 0 -> Done_o, Data_o=0x41.
  - Same frame with parity bit 1 -> ParityError_o pulse, Data_o=0x41, no Done_o.
- Assert Reset in the middle of the data bits of 0x55 -> all outputs 0 within the same cycle.
  - Next frame 0x12 sent after deassertion is received correctly.

Source files
------------

// File: rtl/uart_rx_multi.sv
// uart_rx_multi: parametrised UART receiver.
// Configurable data width, stop-bit count and oversampling ratio.
// It filters false starts, flags framing errors and parks on a held-low line (break).
// Parity checking is optional. Define UART_RX_PARITY_EN to add the PARITY state
// and the PARITY_ODD parameter (0 = even, 1 = odd).
module uart_rx_multi #(
  parameter int CLOCK_HZ   = 10_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1
`ifdef UART_RX_PARITY_EN
  ,
  parameter int PARITY_ODD = 0
`endif
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Rx_i,
  output logic [DATA_BITS-1:0] Data_o,
  output logic                 Done_o,
  output logic                 FrameError_o,
  output logic                 ParityError_o,
  output logic                 Busy_o
);

  localparam int TICKS = CLOCK_HZ / (BAUD * OVERSAMPLE);
  localparam int TW    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int SW    = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);
  localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  if (TICKS < 1) begin : g_err_ticks
    $error("uart_rx_multi: CLOCK_HZ / (BAUD*OVERSAMPLE) must be at least 1");
  end
  if (OVERSAMPLE != 8 && OVERSAMPLE != 16) begin : g_err_os
    $error("uart_rx_multi: OVERSAMPLE must be 8 or 16");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_db
    $error("uart_rx_multi: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_err_sb
    $error("uart_rx_multi: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d;
  logic                   rx_s_q, rx_s_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [1:0]             flush_q, flush_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [SW-1:0]          samp_q, samp_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   stop_bad_q, stop_bad_d;
  logic                   done_q, done_d;
  logic                   ferr_q, ferr_d;
  logic                   busy_q, busy_d;
  logic                   tick;
  logic                   mid;
  logic                   bad;
`ifdef UART_RX_PARITY_EN
  logic                   par_acc_q, par_acc_d;
  logic                   par_bad_q, par_bad_d;
  logic                   perr_q, perr_d;
`endif

  // Next-state logic: synchroniser, tick/sample counters and the receive FSM.
  // The edge detector only arms once the synchroniser has flushed its reset value,
  // so a line sitting low after reset needs a real 1->0 edge before it counts as a start.
  always_comb begin
    sync1_d    = Rx_i;
    rx_s_d     = sync1_q;
    flush_d    = (flush_q == 2'd2) ? flush_q : flush_q + 2'd1;
    rx_prev_d  = (flush_q == 2'd2) ? rx_s_q : 1'b0;
    state_d    = state_q;
    tick_d     = tick_q;
    samp_d     = samp_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    data_d     = data_q;
    stop_bad_d = stop_bad_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    bad        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_acc_d  = par_acc_q;
    par_bad_d  = par_bad_q;
    perr_d     = 1'b0;
`endif

    tick = (tick_q == TICK_LAST);
    mid  = tick && (samp_q == SAMP_MID);

    if (state_q == S_IDLE) begin
      tick_d = '0;
      samp_d = '0;
    end else begin
      tick_d = tick ? '0 : tick_q + TW'(1);
      if (tick) begin
        samp_d = (samp_q == SAMP_LAST) ? '0 : samp_q + SW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (rx_prev_q && !rx_s_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (mid) begin
          if (!rx_s_q) begin
            state_d = S_DATA;
            busy_d  = 1'b1;
            bit_d   = '0;
`ifdef UART_RX_PARITY_EN
            par_acc_d = 1'b0;
            par_bad_d = 1'b0;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (mid) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
          par_acc_d = par_acc_q ^ rx_s_q;
`endif
          if (bit_q == DATA_LAST) begin
            bit_d      = '0;
            stop_bad_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            state_d    = S_PARITY;
`else
            state_d    = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (mid) begin
          par_bad_d = ((par_acc_q ^ rx_s_q) != PARITY_ODD[0]);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (mid) begin
          bad = stop_bad_q | ~rx_s_q;
          if (bit_q == STOP_LAST) begin
            if (bad) begin
              ferr_d  = 1'b1;
              state_d = rx_s_q ? S_IDLE : S_BREAK;
              busy_d  = ~rx_s_q;
            end else begin
              data_d  = shift_q;
`ifdef UART_RX_PARITY_EN
              done_d  = ~par_bad_q;
              perr_d  = par_bad_q;
`else
              done_d  = 1'b1;
`endif
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            stop_bad_d = bad;
            bit_d      = bit_q + 4'd1;
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register: the line idles high, so the synchroniser resets to 1.
  // Every output is registered, so each pulse lands one clock after its deciding sample.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b0;
      flush_q    <= 2'd0;
      state_q    <= S_IDLE;
      tick_q     <= '0;
      samp_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      stop_bad_q <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_acc_q  <= 1'b0;
      par_bad_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      rx_s_q     <= rx_s_d;
      rx_prev_q  <= rx_prev_d;
      flush_q    <= flush_d;
      state_q    <= state_d;
      tick_q     <= tick_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      stop_bad_q <= stop_bad_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_acc_q  <= par_acc_d;
      par_bad_q  <= par_bad_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign Data_o       = data_q;
  assign Done_o       = done_q;
  assign FrameError_o = ferr_q;
  assign Busy_o       = busy_q;
`ifdef UART_RX_PARITY_EN
  assign ParityError_o = perr_q;
`else
  assign ParityError_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_multi.sv
// tb_uart_rx_multi: scoreboard bench for uart_rx_multi.
// It runs at 16 clocks per bit. The default build covers the 8N1 receiver.
// Defining UART_RX_PARITY_EN switches the bench to 7 data bits, 2 stop bits and even parity.
`timescale 1ns/1ps
module tb_uart_rx_multi;

   localparam int CLOCK_HZ   = 16_000_000;
   localparam int BAUD       = 1_000_000;
   localparam int OVERSAMPLE = 16;
`ifdef UART_RX_PARITY_EN
   localparam int DB = 7;
   localparam int SB = 2;
   localparam int PB = 1;
   localparam bit PARITY_ODD = 1'b0;
`else
   localparam int DB = 8;
   localparam int SB = 1;
   localparam int PB = 0;
`endif
   localparam int BITCLK = 16;
   localparam int NBITS  = 1 + DB + PB + SB;
   localparam logic [31:0] MASK = (32'd1 << DB) - 32'd1;

   typedef struct {
      int          kind;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          Rx_i;
   logic [DB-1:0] Data_o;
   logic          Done_o;
   logic          FrameError_o;
   logic          ParityError_o;
   logic          Busy_o;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   exp_t        sb[$];
   logic [31:0] lastGood = 32'd0;
   logic [2:0]  prevPulses = 3'b000;

   uart_rx_multi #(
      .CLOCK_HZ(CLOCK_HZ),
      .BAUD(BAUD),
      .OVERSAMPLE(OVERSAMPLE),
      .DATA_BITS(DB),
      .STOP_BITS(SB)
`ifdef UART_RX_PARITY_EN
      ,
      .PARITY_ODD(0)
`endif
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .Rx_i(Rx_i),
      .Data_o(Data_o),
      .Done_o(Done_o),
      .FrameError_o(FrameError_o),
      .ParityError_o(ParityError_o),
      .Busy_o(Busy_o)
   );

   // 100 MHz-style clock; 16 clocks make one bit at the bench baud rate.
   always #5 Clock = ~Clock;

   // Free-running edge counter used to time-stamp expected pulses.
   always @(posedge Clock) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   function automatic int pulseKind(input logic d, input logic f);
      return d ? 0 : (f ? 1 : 2);
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic driveBit(input logic b);
      Rx_i = b;
      idle(BITCLK);
   endtask

   // Sends one frame and predicts its pulse. The final stop bit is sampled 11 edges
   // after the start-bit drive (2 sync + 1 edge detect + 8 to mid-bit) plus 16 per later bit.
   task automatic applyStimulus(input logic [31:0] data, input bit parFlip, input bit stopVal);
      logic [DB-1:0] d;
      exp_t          e;
      d     = data[DB-1:0];
      e.cyc = cyc + 11 + BITCLK * (NBITS - 1);
      if (!stopVal) begin
         e.kind = 1;
         e.data = lastGood;
      end else begin
         e.kind   = parFlip ? 2 : 0;
         e.data   = data & MASK;
         lastGood = data & MASK;
      end
      sb.push_back(e);
      driveBit(1'b0);
      for (int i = 0; i < DB; i++) begin
         driveBit(d[i]);
         if (i == 1) checkOutput("busy_mid_frame", {31'd0, Busy_o}, 32'd1);
      end
`ifdef UART_RX_PARITY_EN
      driveBit((^d) ^ PARITY_ODD ^ parFlip);
`endif
      for (int i = 0; i < SB; i++) driveBit(stopVal);
   endtask

   // Monitor: every pulse must be expected, single, one clock wide, correctly timed.
   always @(negedge Clock) begin
      if (!Reset && (Done_o || FrameError_o || ParityError_o)) begin
         checkOutput("one_pulse", int'(Done_o) + int'(FrameError_o) + int'(ParityError_o), 32'd1);
         checkOutput("pulse_width", {29'd0, {Done_o, FrameError_o, ParityError_o} & prevPulses}, 32'd0);
         checkOutput("pulse_expected", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            checkOutput("pulse_kind", pulseKind(Done_o, FrameError_o), sb[0].kind);
            checkOutput("pulse_data", {{(32-DB){1'b0}}, Data_o}, sb[0].data);
            checkOutput("pulse_latency", cyc, sb[0].cyc);
            void'(sb.pop_front());
         end
      end
      prevPulses <= {Done_o, FrameError_o, ParityError_o};
   end

   // Watchdog so a stuck run still reports and ends.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      Reset = 1'b1;
      Rx_i  = 1'b1;
      idle(3);
      checkOutput("reset_data", {{(32-DB){1'b0}}, Data_o}, 32'd0);
      checkOutput("reset_done", {31'd0, Done_o}, 32'd0);
      checkOutput("reset_ferr", {31'd0, FrameError_o}, 32'd0);
      checkOutput("reset_perr", {31'd0, ParityError_o}, 32'd0);
      checkOutput("reset_busy", {31'd0, Busy_o}, 32'd0);
      Reset = 1'b0;
      idle(6);

      $display("[TB] single frame 0xA5");
      applyStimulus(32'hA5, 1'b0, 1'b1);
      idle(4);
      checkOutput("a5_busy_after", {31'd0, Busy_o}, 32'd0);
      checkOutput("a5_data_held", {{(32-DB){1'b0}}, Data_o}, 32'hA5 & MASK);

      $display("[TB] back-to-back 0x00 then 0xFF");
      applyStimulus(32'h00, 1'b0, 1'b1);
      applyStimulus(32'hFF, 1'b0, 1'b1);
      idle(4);
      checkOutput("b2b_data", {{(32-DB){1'b0}}, Data_o}, 32'hFF & MASK);

      $display("[TB] 4-clock low glitch");
      Rx_i = 1'b0;
      idle(4);
      Rx_i = 1'b1;
      idle(10);
      checkOutput("glitch_busy_mid", {31'd0, Busy_o}, 32'd0);
      idle(30);
      checkOutput("glitch_busy_after", {31'd0, Busy_o}, 32'd0);
      applyStimulus(32'h5A, 1'b0, 1'b1);
      idle(4);
      checkOutput("post_glitch_data", {{(32-DB){1'b0}}, Data_o}, 32'h5A & MASK);

      $display("[TB] framing error 0x3C then held-low break");
      applyStimulus(32'h3C, 1'b0, 1'b0);
      idle(40);
      checkOutput("break_busy", {31'd0, Busy_o}, 32'd1);
      checkOutput("ferr_data_kept", {{(32-DB){1'b0}}, Data_o}, 32'h5A & MASK);
      Rx_i = 1'b1;
      idle(8);
      checkOutput("break_released", {31'd0, Busy_o}, 32'd0);
      idle(20);

`ifdef UART_RX_PARITY_EN
      $display("[TB] parity frames 0x41");
      applyStimulus(32'h41, 1'b0, 1'b1);
      idle(8);
      applyStimulus(32'h41, 1'b1, 1'b1);
      idle(8);
      checkOutput("perr_data", {{(32-DB){1'b0}}, Data_o}, 32'h41 & MASK);
`endif

      $display("[TB] reset in the middle of 0x55");
      Rx_i = 1'b0;
      idle(BITCLK);
      Rx_i = 1'b1;
      idle(BITCLK);
      Rx_i = 1'b0;
      idle(BITCLK);
      Rx_i = 1'b1;
      idle(BITCLK);
      Rx_i = 1'b0;
      idle(8);
      checkOutput("busy_before_reset", {31'd0, Busy_o}, 32'd1);
      Reset = 1'b1;
      #1;
      checkOutput("midreset_data", {{(32-DB){1'b0}}, Data_o}, 32'd0);
      checkOutput("midreset_busy", {31'd0, Busy_o}, 32'd0);
      checkOutput("midreset_pulses", {29'd0, Done_o, FrameError_o, ParityError_o}, 32'd0);
      lastGood = 32'd0;
      idle(3);
      Reset = 1'b0;
      idle(30);
      checkOutput("low_line_after_reset", {31'd0, Busy_o}, 32'd0);
      Rx_i = 1'b1;
      idle(8);
      applyStimulus(32'h12, 1'b0, 1'b1);
      idle(4);
      checkOutput("post_reset_data", {{(32-DB){1'b0}}, Data_o}, 32'h12 & MASK);

      for (int i = 0; i < 200 && sb.size() != 0; i++) idle(1);
      checkOutput("scoreboard_drained", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
